reglk_bank: RTL and testbench

Lock-register bank that produces the `reglk` words and clears them, consumed by peripheral lock-gating logic. Software sets lock bits through a single-outstanding req/gnt/rvalid register port. Lock bits are set-only, and a sticky global lock freezes the whole bank. The bank is cleared only by reset or by an authenticated JTAG unlock sequence, which wipes one word per cycle.

---
 rtl/reglk_pkg.sv | 25 ++
 rtl/reglk_bank.sv | 195 +++++++++++++++++++
 tb/tb_reglk_bank.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reglk_pkg.sv
// Shared types and constants for the lock-register bank.
// CTRL and VIOL sit directly above the lock words, so their addresses
// are derived from the word count through the helper functions below.
package reglk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    CLEAR = 2'd2
  } reglk_state_e;

  localparam int CTRL_OFS  = 0;
  localparam int VIOL_OFS  = 1;
  localparam int VIOL_W    = 8;
  localparam int GLOCK_BIT = 0;

  function automatic int ctrl_addr(input int num_words);
    return num_words + CTRL_OFS;
  endfunction

  function automatic int viol_addr(input int num_words);
    return num_words + VIOL_OFS;
  endfunction

endpackage

// File: rtl/reglk_bank.sv
// Lock-register bank: set-only lock words, a sticky global lock, a
// single-outstanding req/gnt/rvalid register port and an authenticated
// JTAG unlock that wipes one word per cycle.
// Optional macro REGLK_VIOL_CNT_EN builds the saturating violation counter;
// without it VIOL reads 0 and has no flops.
module reglk_bank
  import reglk_pkg::*;
#(
  parameter int NUM_WORDS = 6,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [ADDR_W-1:0]           addr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        err_o,
  input  logic                        jtag_unlock_i,
  input  logic                        auth_ok_i,
  output logic                        glock_o,
  output logic [NUM_WORDS*DATA_W-1:0] reglk_o
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(ctrl_addr(NUM_WORDS));
  localparam logic [ADDR_W-1:0] VIOL_ADDR = ADDR_W'(viol_addr(NUM_WORDS));
  localparam logic [ADDR_W-1:0] WORD_LIM  = ADDR_W'(NUM_WORDS);

  reglk_state_e      state_q, state_d;
  logic [DATA_W-1:0] words_q [NUM_WORDS];
  logic [DATA_W-1:0] words_d [NUM_WORDS];
  logic              glock_q, glock_d;
  logic              jtag_q, jtag_d;
  logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              unlock_edge;
  logic [1:0]        viol_inc;
  logic [VIOL_W-1:0] viol_val;

  // Next-state logic: unlock beats a request, writes commit at the grant edge,
  // CLEAR walks the word array and drops the global lock on its last cycle.
  always_comb begin
    state_d     = state_q;
    words_d     = words_q;
    glock_d     = glock_q;
    clr_cnt_d   = clr_cnt_q;
    addr_d      = addr_q;
    err_d       = err_q;
    jtag_d      = jtag_unlock_i;
    viol_inc    = 2'd0;
    gnt_o       = 1'b0;
    unlock_edge = jtag_unlock_i & ~jtag_q;
    unique case (state_q)
      IDLE: begin
        if (unlock_edge && auth_ok_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else begin
          if (unlock_edge) begin
            viol_inc = viol_inc + 2'd1;
          end
          if (req_i) begin
            gnt_o   = 1'b1;
            state_d = RESP;
            addr_d  = addr_i;
            err_d   = 1'b0;
            if (we_i) begin
              if ((addr_i < WORD_LIM) && !glock_q) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                  if (addr_i == ADDR_W'(i)) begin
                    words_d[i] = words_q[i] | wdata_i;
                  end
                end
              end else if ((addr_i == CTRL_ADDR) && !glock_q) begin
                if (wdata_i[GLOCK_BIT]) begin
                  glock_d = 1'b1;
                end
              end else begin
                err_d    = 1'b1;
                viol_inc = viol_inc + 2'd1;
              end
            end else begin
              err_d = !((addr_i < WORD_LIM) || (addr_i == CTRL_ADDR) ||
                        (addr_i == VIOL_ADDR));
            end
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      CLEAR: begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          if (clr_cnt_q == CNT_W'(i)) begin
            words_d[i] = '0;
          end
        end
        if (clr_cnt_q == CNT_W'(NUM_WORDS - 1)) begin
          glock_d   = 1'b0;
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, word array and control registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      glock_q   <= 1'b0;
      jtag_q    <= 1'b0;
      clr_cnt_q <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        words_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      glock_q   <= glock_d;
      jtag_q    <= jtag_d;
      clr_cnt_q <= clr_cnt_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      words_q   <= words_d;
    end
  end

`ifdef REGLK_VIOL_CNT_EN
  logic [VIOL_W-1:0] viol_q, viol_d;
  logic [VIOL_W:0]   viol_sum;

  // Saturating add of this cycle's violations.
  always_comb begin
    viol_sum = {1'b0, viol_q} + (VIOL_W + 1)'(viol_inc);
    viol_d   = viol_sum[VIOL_W] ? {VIOL_W{1'b1}} : viol_sum[VIOL_W-1:0];
  end

  // Violation counter register; survives an unlock, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      viol_q <= '0;
    end else begin
      viol_q <= viol_d;
    end
  end

  assign viol_val = viol_q;
`else
  logic unused_viol_inc;
  assign unused_viol_inc = ^viol_inc;
  assign viol_val        = '0;
`endif

  // Response path: read data is taken from the registered state, so a write
  // in the same transaction is already visible.
  always_comb begin
    rvalid_o = (state_q == RESP);
    err_o    = (state_q == RESP) && err_q;
    rdata_o  = '0;
    if (state_q == RESP) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (addr_q == ADDR_W'(i)) begin
          rdata_o = words_q[i];
        end
      end
      if (addr_q == CTRL_ADDR) begin
        rdata_o[GLOCK_BIT] = glock_q;
      end else if (addr_q == VIOL_ADDR) begin
        rdata_o = DATA_W'(viol_val);
      end
    end
  end

  // Flatten the word array for the lock-gating consumers.
  always_comb begin
    glock_o = glock_q;
    for (int i = 0; i < NUM_WORDS; i++) begin
      reglk_o[i*DATA_W +: DATA_W] = words_q[i];
    end
  end

endmodule

// File: tb/tb_reglk_bank.sv
// Self-checking bench for reglk_bank: a vector table for the basic register
// behaviour, hand-written unlock/reset sequences and a random phase checked
// against a small behavioural model of the bank.
module tb_reglk_bank;

  localparam int NW = 6;

`ifdef REGLK_VIOL_CNT_EN
  localparam bit VIOL_ON = 1'b1;
`else
  localparam bit VIOL_ON = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_i;
  logic          we_i;
  logic [3:0]    addr_i;
  logic [31:0]   wdata_i;
  logic          gnt_o;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic          jtag_unlock_i;
  logic          auth_ok_i;
  logic          glock_o;
  logic [NW*32-1:0] reglk_o;

  int nTotal = 0;
  int nBad   = 0;

  logic [31:0] mWords [NW];
  logic        mGlock;
  int          mViol;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        chkRd;
    logic [31:0] expRd;
    logic        expErr;
  } vec_t;

  vec_t vecs [24];

  reglk_bank dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .we_i          (we_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .err_o         (err_o),
    .jtag_unlock_i (jtag_unlock_i),
    .auth_ok_i     (auth_ok_i),
    .glock_o       (glock_o),
    .reglk_o       (reglk_o)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NW; i++) mWords[i] = '0;
    mGlock = 1'b0;
    mViol  = 0;
  endtask

  task automatic modelViolation();
    if (VIOL_ON && mViol < 255) mViol++;
  endtask

  // Register-port behaviour written directly from the address map rules.
  task automatic modelAccess(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er);
    rd = '0;
    er = 1'b0;
    if (we) begin
      if (addr < NW && !mGlock) mWords[addr] = mWords[addr] | wd;
      else if (addr == NW && !mGlock) begin
        if (wd[0]) mGlock = 1'b1;
      end else begin
        er = 1'b1;
        modelViolation();
      end
    end
    if (addr < NW) rd = mWords[addr];
    else if (addr == NW) rd = {31'b0, mGlock};
    else if (addr == NW + 1) rd = 32'(mViol);
    else if (!we) er = 1'b1;
  endtask

  task automatic compareState(input string tag);
    for (int i = 0; i < NW; i++)
      checkOutput($sformatf("%s reglk[%0d]", tag, i), reglk_o[i*32 +: 32], mWords[i]);
    checkOutput({tag, " glock"}, 32'(glock_o), 32'(mGlock));
  endtask

  // One full access: grant in the driven cycle, response in the next.
  task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                               output logic [31:0] rd, output logic er);
    @(negedge clk_i);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wd;
    #1;
    checkOutput("gnt", 32'(gnt_o), 32'd1);
    checkOutput("rvalid idle", 32'(rvalid_o), 32'd0);
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    checkOutput("rvalid", 32'(rvalid_o), 32'd1);
    rd = rdata_o;
    er = err_o;
  endtask

  task automatic doAccess(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
    logic [31:0] mrd;
    logic        mer;
    modelAccess(we, addr, wd, mrd, mer);
    applyStimulus(we, addr, wd, rd, er);
    checkOutput($sformatf("err a=%0d we=%0d", addr, we), 32'(er), 32'(mer));
    if (!we) checkOutput($sformatf("rdata a=%0d", addr), rd, mrd);
    compareState("post-access");
  endtask

  // Unlock edge with or without authentication, no request pending.
  task automatic doUnlock(input logic auth);
    @(negedge clk_i);
    jtag_unlock_i = 1'b1;
    auth_ok_i     = auth;
    if (auth) begin
      repeat (NW) @(negedge clk_i);
      for (int i = 0; i < NW; i++) mWords[i] = '0;
      mGlock = 1'b0;
    end else begin
      modelViolation();
    end
    @(negedge clk_i);
    jtag_unlock_i = 1'b0;
    auth_ok_i     = 1'b0;
    #1;
    compareState(auth ? "unlock" : "unauth");
    @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [3:0]  a;
    logic [31:0] wd;
    logic        w;

    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    jtag_unlock_i = 1'b0; auth_ok_i = 1'b0;
    modelReset();
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("reset rvalid", 32'(rvalid_o), 32'd0);
    checkOutput("reset err", 32'(err_o), 32'd0);
    checkOutput("reset rdata", rdata_o, 32'd0);
    compareState("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Basic register behaviour as a vector table.
    for (int i = 0; i < NW; i++) vecs[i] = '{1'b0, 4'(i), 32'h0, 1'b1, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 4'd6,  32'h0,         1'b1, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 4'd2,  32'h0000_00F0, 1'b0, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 4'd2,  32'h0000_000F, 1'b0, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 4'd2,  32'h0,         1'b1, 32'h0000_00FF, 1'b0};
    vecs[10] = '{1'b1, 4'd2,  32'h0,         1'b0, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 4'd2,  32'h0,         1'b1, 32'h0000_00FF, 1'b0};
    vecs[12] = '{1'b1, 4'd4,  32'hA5A5_0000, 1'b0, 32'h0, 1'b0};
    vecs[13] = '{1'b1, 4'd5,  32'h8000_0001, 1'b0, 32'h0, 1'b0};
    vecs[14] = '{1'b1, 4'd6,  32'h0000_0001, 1'b0, 32'h0, 1'b0};
    vecs[15] = '{1'b1, 4'd0,  32'h0000_0001, 1'b0, 32'h0, 1'b1};
    vecs[16] = '{1'b0, 4'd0,  32'h0,         1'b1, 32'h0, 1'b0};
    vecs[17] = '{1'b0, 4'd6,  32'h0,         1'b1, 32'h1, 1'b0};
    vecs[18] = '{1'b0, 4'd7,  32'h0,         1'b1, VIOL_ON ? 32'd1 : 32'd0, 1'b0};
    vecs[19] = '{1'b0, 4'd15, 32'h0,         1'b1, 32'h0, 1'b1};
    vecs[20] = '{1'b1, 4'd7,  32'h0000_0055, 1'b0, 32'h0, 1'b1};
    vecs[21] = '{1'b0, 4'd7,  32'h0,         1'b1, VIOL_ON ? 32'd2 : 32'd0, 1'b0};
    vecs[22] = '{1'b1, 4'd6,  32'h0000_0000, 1'b0, 32'h0, 1'b1};
    vecs[23] = '{1'b0, 4'd4,  32'h0,         1'b1, 32'hA5A5_0000, 1'b0};
    for (int i = 0; i < 24; i++) begin
      doAccess(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er);
      checkOutput($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].expErr));
      if (vecs[i].chkRd) checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].expRd);
    end

    // Authenticated unlock racing a read request: unlock wins, the read is
    // granted in the first IDLE cycle after the wipe.
    @(negedge clk_i);
    jtag_unlock_i = 1'b1; auth_ok_i = 1'b1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 4'd4;
    #1;
    checkOutput("unlock gnt", 32'(gnt_o), 32'd0);
    for (int k = 0; k < NW; k++) begin
      @(negedge clk_i);
      #1;
      checkOutput($sformatf("clear%0d gnt", k), 32'(gnt_o), 32'd0);
      checkOutput($sformatf("clear%0d rvalid", k), 32'(rvalid_o), 32'd0);
      checkOutput($sformatf("clear%0d glock", k), 32'(glock_o), 32'd1);
      for (int j = 0; j < k; j++)
        checkOutput($sformatf("clear%0d word%0d", k, j), reglk_o[j*32 +: 32], 32'h0);
    end
    for (int i = 0; i < NW; i++) mWords[i] = '0;
    mGlock = 1'b0;
    @(negedge clk_i);
    #1;
    compareState("after clear");
    checkOutput("post-clear gnt", 32'(gnt_o), 32'd1);
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    checkOutput("post-clear rvalid", 32'(rvalid_o), 32'd1);
    checkOutput("post-clear rdata", rdata_o, 32'h0);
    checkOutput("post-clear err", 32'(err_o), 32'd0);
    jtag_unlock_i = 1'b0; auth_ok_i = 1'b0;
    @(negedge clk_i);

    // Unauthenticated unlocks saturate VIOL and never clear anything.
    doAccess(1'b1, 4'd1, 32'h0000_1234, rd, er);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      jtag_unlock_i = 1'b1;
      modelViolation();
      @(negedge clk_i);
      jtag_unlock_i = 1'b0;
    end
    #1;
    compareState("after 300 unauth");
    doAccess(1'b0, 4'd7, 32'h0, rd, er);
    checkOutput("viol saturated", rd, VIOL_ON ? 32'hFF : 32'h0);

    // Random accesses and unlocks against the model.
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        doUnlock(1'($urandom_range(0, 1)));
      end else begin
        w  = 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
        wd = $urandom & $urandom;
        if (a == 4'd6) wd[0] = ($urandom_range(0, 7) == 0);
        doAccess(w, a, wd, rd, er);
      end
    end

    // Reset in the third CLEAR cycle.
    doUnlock(1'b1);
    doAccess(1'b1, 4'd1, 32'h0000_0055, rd, er);
    doAccess(1'b1, 4'd3, 32'h0000_0077, rd, er);
    @(negedge clk_i);
    jtag_unlock_i = 1'b1; auth_ok_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1; jtag_unlock_i = 1'b0; auth_ok_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    modelReset();
    #1;
    checkOutput("mid-clear reset rvalid", 32'(rvalid_o), 32'd0);
    checkOutput("mid-clear reset err", 32'(err_o), 32'd0);
    compareState("mid-clear reset");
    doAccess(1'b0, 4'd7, 32'h0, rd, er);
    doAccess(1'b0, 4'd3, 32'h0, rd, er);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
